generador_trafico: RTL and testbench
====================================

Name: generador_trafico

Overview:
Synthesizable, parametrised traffic generator and sink for the arqui datapath. It programs the FIFO almost-full/almost-empty thresholds, then pushes a burst of incrementing words into the main FIFO while honouring fifo_pause_main. It drains NUM_DEST destination FIFOs and counts accepted pops per destination, then reports pass/fail. Instantiated beside the arqui top in place of the behavioural bench so that long runs can be made on FPGA and in gate-level simulation.

Parameters:
DATA_W, 6, width of main FIFO words and destination outputs
NUM_DEST, 2, number of destination FIFOs drained
CNT_W, 8, width of burst length and all counters
CFG_CYCLES, 2, cycles init stays high, and also the settle cycles after it
TIMEOUT, 32, cycles in DRAIN without an accepted pop before failure

Ports:
clk  in  1  clock; all logic on rising edge
reset_L  in  1  synchronous, active-low reset
start  in  1  level; sampled only in IDLE
burst_len  in  CNT_W  words to push; 0 is legal
seed  in  DATA_W  first pushed word
cfg_thr  in  20  packed thresholds {afMF[1:0],aeMF[1:0],afVC[3:0],aeVC[3:0],afDF[1:0],aeDF[1:0],4'b0}; low 4 bits ignored
fifo_pause_main  in  1  main FIFO back-pressure
fifo_empty  in  NUM_DEST  destination FIFO empty flags
data_out  in  NUM_DEST*DATA_W  destination data; unused except for lint
data_in  out  DATA_W  word to main FIFO
push_main  out  1  push strobe
pop  out  NUM_DEST  pop strobes
init  out  1  threshold-load strobe
afMF_i, aeMF_i  out  2 each  main FIFO thresholds
afVC_i, aeVC_i  out  4 each  VC FIFO thresholds
afDF_i, aeDF_i  out  2 each  D FIFO thresholds
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
err  out  2  bit0 timeout; bit1 overflow (received > sent)
sent_cnt  out  CNT_W  accepted pushes
recv_cnt  out  NUM_DEST*CNT_W  accepted pops per destination

Behaviour:
- All outputs are registered.
- Reset (reset_L=0 at an edge), regardless of state:
  - state goes to IDLE;
  - data_in, push_main, pop, init, busy, done, err and all counters go to 0;
  - threshold outputs load the defaults afMF=3, aeMF=1, afVC=14, aeVC=2, afDF=3, aeDF=1.
- FSM states: IDLE, CONFIG, SETTLE, PUSH, DRAIN, DONE.
- IDLE:
  - start=1 moves to CONFIG.
  - On that same edge: thresholds load from cfg_thr, counters clear, err clears.
- CONFIG: init=1 for exactly CFG_CYCLES cycles, then SETTLE.
- SETTLE: init=0 for CFG_CYCLES cycles, then PUSH.
- PUSH:
  - Each edge where remaining>0 and fifo_pause_main=0: push_main<=1, data_in<=next word, sent_cnt++.
  - Otherwise push_main<=0 and data_in holds.
  - Word sequence is seed, seed+1, and so on, mod 2^DATA_W (wrap 63 -> 0 at DATA_W=6).
  - Pause is sampled registered, so one word may be pushed in the cycle after pause rises. The downstream almost-full margin absorbs it.
  - Leaves to DRAIN on the edge after the last push. burst_len=0 goes straight to DRAIN.
- pop[i] rule in PUSH and DRAIN: pop[i]<=~fifo_empty[i]. In all other states pop=0.
- Pop acceptance: a pop is accepted in a cycle where pop[i]=1 and fifo_empty[i]=0. recv_cnt[i] then increments on that edge. A pop issued against an empty FIFO is not counted.
- DRAIN:
  - Idle counter clears on any accepted pop and otherwise increments.
  - When the sum of recv_cnt equals sent_cnt: go to DONE with err=0.
  - When the sum exceeds sent_cnt: go to DONE with err[1]=1.
  - When the idle counter reaches TIMEOUT: go to DONE with err[0]=1.
  - If both end conditions hold on the same edge, DONE is entered and both applicable bits set.
- DONE:
  - done=1; counters and err hold.
  - Moves to IDLE when start=0. done clears on that edge.
- start is ignored outside IDLE and DONE.
- Counters saturate at 2^CNT_W-1 and never wrap.

Decomposition:
- Package gen_trafico_pkg:
  - state encoding constants;
  - default threshold constants;
  - field offsets within cfg_thr;
  - err bit indices.
- Sub-module monitor_destino, instantiated NUM_DEST times via generate. It contains the registered pop for one destination, acceptance detection and the saturating recv counter.

Test Plan:
1. Reset: hold reset_L=0 for 3 cycles mid-PUSH. Next edge: push_main=0, pop=0, afVC_i=14, aeVC_i=2, state IDLE.
2. Config: start=1 with cfg_thr thresholds afMF=2, aeMF=1, afVC=12, aeVC=3, afDF=2, aeDF=1. Expect init high for exactly 2 cycles; thresholds visible on the first CONFIG cycle; first push 4 cycles after start is sampled.
3. Burst with pause: seed=6'b101100, burst_len=8, ideal FIFO model. Expect data_in sequence 44..51, sent_cnt=8, sum of recv=8, done=1, err=0.
4. Pause: force pause high for 5 cycles mid-burst. Expect push_main=0 from the second paused cycle onward, no data_in advance while low, and sequence continuity after release.
5. Wrap: seed=62, burst_len=4. Expect words 62, 63, 0, 1.
6. Timeout: burst_len=3 with a model that drops one word. Expect DONE after 32 idle cycles, err=2'b01, recv sum=2.

Source files
------------

// File: rtl/gen_trafico_pkg.sv
// Shared constants for the traffic generator: state encoding, default
// FIFO thresholds, field positions inside cfg_thr and err bit indices.
package gen_trafico_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_SETTLE = 3'd2,
    ST_PUSH   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] DEF_AF_MF = 2'd3;
  localparam logic [1:0] DEF_AE_MF = 2'd1;
  localparam logic [3:0] DEF_AF_VC = 4'd14;
  localparam logic [3:0] DEF_AE_VC = 4'd2;
  localparam logic [1:0] DEF_AF_DF = 2'd3;
  localparam logic [1:0] DEF_AE_DF = 2'd1;

  localparam int OFS_AF_MF = 18;
  localparam int OFS_AE_MF = 16;
  localparam int OFS_AF_VC = 12;
  localparam int OFS_AE_VC = 8;
  localparam int OFS_AF_DF = 6;
  localparam int OFS_AE_DF = 4;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_OVERFLOW = 1;

endpackage

// File: rtl/generador_trafico_monitor_destino.sv
// One destination sink: registered pop, acceptance detect and a saturating
// count of accepted pops.
module monitor_destino #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             clear,
  input  logic             pop_en,
  input  logic             fifo_empty,
  output logic             pop,
  output logic             accept,
  output logic [CNT_W-1:0] recv_cnt
);

  // A pop only counts if the FIFO still holds data while the strobe is high.
  assign accept = pop & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      pop      <= 1'b0;
      recv_cnt <= '0;
    end else begin
      pop <= pop_en & ~fifo_empty;
      if (clear)
        recv_cnt <= '0;
      else if (accept && (recv_cnt != '1))
        recv_cnt <= recv_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/generador_trafico.sv
// Traffic generator/sink: loads FIFO thresholds, pushes an incrementing burst
// into the main FIFO, drains the destination FIFOs and reports the outcome.
//
// state  | meaning
// IDLE   | waiting for start
// CONFIG | init high, thresholds being loaded downstream
// SETTLE | init low, letting the FIFOs settle
// PUSH   | pushing the burst, honouring fifo_pause_main
// DRAIN  | popping until all words are back, overflow or timeout
// DONE   | result held until start drops
module generador_trafico
  import gen_trafico_pkg::*;
#(
  parameter int DATA_W     = 6,
  parameter int NUM_DEST   = 2,
  parameter int CNT_W      = 8,
  parameter int CFG_CYCLES = 2,
  parameter int TIMEOUT    = 32
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         start,
  input  logic [CNT_W-1:0]             burst_len,
  input  logic [DATA_W-1:0]            seed,
  input  logic [19:0]                  cfg_thr,
  input  logic                         fifo_pause_main,
  input  logic [NUM_DEST-1:0]          fifo_empty,
  input  logic [NUM_DEST*DATA_W-1:0]   data_out,
  output logic [DATA_W-1:0]            data_in,
  output logic                         push_main,
  output logic [NUM_DEST-1:0]          pop,
  output logic                         init,
  output logic [1:0]                   afMF_i,
  output logic [1:0]                   aeMF_i,
  output logic [3:0]                   afVC_i,
  output logic [3:0]                   aeVC_i,
  output logic [1:0]                   afDF_i,
  output logic [1:0]                   aeDF_i,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   err,
  output logic [CNT_W-1:0]             sent_cnt,
  output logic [NUM_DEST*CNT_W-1:0]    recv_cnt
);

  localparam int SUM_W = CNT_W + $clog2(NUM_DEST) + 1;
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(CFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT - 1);

  state_t              state;
  logic [CNT_W-1:0]    phase_cnt;
  logic [CNT_W-1:0]    idle_cnt;
  logic [CNT_W-1:0]    burst_q;
  logic [DATA_W-1:0]   seed_q;
  logic [NUM_DEST-1:0] accept;
  logic [SUM_W-1:0]    recv_sum;
  logic [DATA_W-1:0]   next_word;
  logic                any_accept;
  logic                sum_eq;
  logic                sum_over;
  logic                idle_tmo;
  logic                finish;
  logic                pop_en;
  logic                clear;
  logic                push_now;
  logic                unused_bits;

  assign unused_bits = ^{data_out, cfg_thr[3:0]};

  always_comb begin
    recv_sum = '0;
    for (int i = 0; i < NUM_DEST; i++)
      recv_sum = recv_sum + SUM_W'(recv_cnt[i*CNT_W +: CNT_W]);
  end

  assign any_accept = |accept;
  assign sum_eq     = (recv_sum == SUM_W'(sent_cnt));
  assign sum_over   = (recv_sum >  SUM_W'(sent_cnt));
  assign idle_tmo   = !any_accept && (idle_cnt == IDLE_LAST);
  assign finish     = (state == ST_DRAIN) && (sum_eq || sum_over || idle_tmo);
  // Stop popping on the exit edge so no word is pulled without being counted.
  assign pop_en     = (state == ST_PUSH) || ((state == ST_DRAIN) && !finish);
  assign clear      = (state == ST_IDLE) && start;
  assign next_word  = seed_q + DATA_W'(sent_cnt);
  assign push_now   = ((state == ST_PUSH) || ((state == ST_SETTLE) && (phase_cnt == '0)))
                      && (sent_cnt != burst_q) && !fifo_pause_main;

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
    monitor_destino #(.CNT_W(CNT_W)) u_mon (
      .clk        (clk),
      .reset_L    (reset_L),
      .clear      (clear),
      .pop_en     (pop_en),
      .fifo_empty (fifo_empty[g]),
      .pop        (pop[g]),
      .accept     (accept[g]),
      .recv_cnt   (recv_cnt[g*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state     <= ST_IDLE;
      data_in   <= '0;
      push_main <= 1'b0;
      init      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= '0;
      sent_cnt  <= '0;
      idle_cnt  <= '0;
      phase_cnt <= '0;
      burst_q   <= '0;
      seed_q    <= '0;
      afMF_i    <= DEF_AF_MF;
      aeMF_i    <= DEF_AE_MF;
      afVC_i    <= DEF_AF_VC;
      aeVC_i    <= DEF_AE_VC;
      afDF_i    <= DEF_AF_DF;
      aeDF_i    <= DEF_AE_DF;
    end else begin
      push_main <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_CONFIG;
            init      <= 1'b1;
            busy      <= 1'b1;
            phase_cnt <= PHASE_LOAD;
            sent_cnt  <= '0;
            idle_cnt  <= '0;
            err       <= '0;
            burst_q   <= burst_len;
            seed_q    <= seed;
            afMF_i    <= cfg_thr[OFS_AF_MF +: 2];
            aeMF_i    <= cfg_thr[OFS_AE_MF +: 2];
            afVC_i    <= cfg_thr[OFS_AF_VC +: 4];
            aeVC_i    <= cfg_thr[OFS_AE_VC +: 4];
            afDF_i    <= cfg_thr[OFS_AF_DF +: 2];
            aeDF_i    <= cfg_thr[OFS_AE_DF +: 2];
          end
        end
        ST_CONFIG: begin
          if (phase_cnt == '0) begin
            state     <= ST_SETTLE;
            init      <= 1'b0;
            phase_cnt <= PHASE_LOAD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          // The settle window's last edge already acts as the first push edge.
          if (phase_cnt == '0)
            state <= (burst_q == '0) ? ST_DRAIN : ST_PUSH;
          else
            phase_cnt <= phase_cnt - 1'b1;
        end
        ST_PUSH: begin
          if (sent_cnt == burst_q)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (finish) begin
            state              <= ST_DONE;
            busy               <= 1'b0;
            done               <= 1'b1;
            err[ERR_TIMEOUT]   <= idle_tmo;
            err[ERR_OVERFLOW]  <= sum_over;
          end else if (any_accept) begin
            idle_cnt <= '0;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!start) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (push_now) begin
        push_main <= 1'b1;
        data_in   <= next_word;
        sent_cnt  <= sent_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_generador_trafico.sv
// Bench for generador_trafico: ideal destination FIFOs routed by word parity,
// per-cycle push/data/init expectations and end-of-run result checks.
module tb_generador_trafico;

  localparam int DATA_W     = 6;
  localparam int NUM_DEST   = 2;
  localparam int CNT_W      = 8;
  localparam int CFG_CYCLES = 2;
  localparam int TIMEOUT    = 32;

  logic                        clk;
  logic                        reset_L;
  logic                        start;
  logic [CNT_W-1:0]            burst_len;
  logic [DATA_W-1:0]           seed;
  logic [19:0]                 cfg_thr;
  logic                        fifo_pause_main;
  logic [NUM_DEST-1:0]         fifo_empty;
  logic [NUM_DEST*DATA_W-1:0]  data_out;
  logic [DATA_W-1:0]           data_in;
  logic                        push_main;
  logic [NUM_DEST-1:0]         pop;
  logic                        init;
  logic [1:0]                  afMF_i, aeMF_i, afDF_i, aeDF_i;
  logic [3:0]                  afVC_i, aeVC_i;
  logic                        busy;
  logic                        done;
  logic [1:0]                  err;
  logic [CNT_W-1:0]            sent_cnt;
  logic [NUM_DEST*CNT_W-1:0]   recv_cnt;

  generador_trafico #(
    .DATA_W(DATA_W), .NUM_DEST(NUM_DEST), .CNT_W(CNT_W),
    .CFG_CYCLES(CFG_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .burst_len(burst_len),
    .seed(seed), .cfg_thr(cfg_thr), .fifo_pause_main(fifo_pause_main),
    .fifo_empty(fifo_empty), .data_out(data_out), .data_in(data_in),
    .push_main(push_main), .pop(pop), .init(init),
    .afMF_i(afMF_i), .aeMF_i(aeMF_i), .afVC_i(afVC_i), .aeVC_i(aeVC_i),
    .afDF_i(afDF_i), .aeDF_i(aeDF_i), .busy(busy), .done(done), .err(err),
    .sent_cnt(sent_cnt), .recv_cnt(recv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk = 0;
  int c0 = 0;
  int m_sent, m_len, drop_idx, ps, pl;
  int m_seed;
  bit rnd_pause;
  int pend [NUM_DEST];
  logic [NUM_DEST-1:0] prev_pop, prev_empty;
  bit prev_push, prev_drop;
  int prev_dest;
  int acc_total, last_acc;

  task automatic chk_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int recv_sum();
    int s = 0;
    for (int i = 0; i < NUM_DEST; i++) s += int'(recv_cnt[i*CNT_W +: CNT_W]);
    return s;
  endfunction

  // One clock: settle the FIFO model for the edge, then observe and drive.
  task automatic tick();
    bit exp_push;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NUM_DEST; i++)
      if (prev_pop[i] && !prev_empty[i] && pend[i] > 0) begin
        pend[i]--;
        acc_total++;
        last_acc = cyc;
      end
    if (prev_push && !prev_drop) pend[prev_dest]++;
    #1;
    prev_drop = 1'b0;
    if (chk) begin
      exp_push = (cyc >= c0 + 5) && (m_sent < m_len) && !fifo_pause_main;
      chk_val("init", init, (cyc == c0 + 1 || cyc == c0 + 2));
      chk_val("push_main", push_main, exp_push);
      if (push_main) begin
        chk_val("data_in", data_in, (m_seed + m_sent) % 64);
        prev_drop = (m_sent == drop_idx);
        m_sent++;
      end else if (m_sent > 0) begin
        chk_val("data_hold", data_in, (m_seed + m_sent - 1) % 64);
      end
    end
    prev_push = push_main;
    prev_dest = int'(data_in) % NUM_DEST;
    prev_pop  = pop;
    for (int i = 0; i < NUM_DEST; i++) fifo_empty[i] = (pend[i] == 0);
    prev_empty = fifo_empty;
    fifo_pause_main = chk && ((cyc >= c0 + ps && cyc < c0 + ps + pl) ||
                              (rnd_pause && $urandom_range(0, 3) == 0));
  endtask

  task automatic run(input int s, input int len, input logic [19:0] cfg, input int drop,
                     input int pst, input int pln, input bit rp, input logic [1:0] exp_err);
    int n;
    int exp_recv;
    seed = DATA_W'(s); burst_len = CNT_W'(len); cfg_thr = cfg;
    m_seed = s; m_len = len; m_sent = 0; drop_idx = drop;
    ps = pst; pl = pln; rnd_pause = rp;
    acc_total = 0; last_acc = cyc;
    c0 = cyc; chk = 1; start = 1'b1;
    tick();
    chk_val("busy_cfg", busy, 1);
    chk_val("done_cfg", done, 0);
    chk_val("thresholds", {afMF_i, aeMF_i, afVC_i, aeVC_i, afDF_i, aeDF_i}, cfg[19:4]);
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    chk_val("done", done, 1);
    exp_recv = (drop >= 0 && drop < len) ? len - 1 : len;
    chk_val("sent_cnt", sent_cnt, len);
    chk_val("recv_sum", recv_sum(), exp_recv);
    chk_val("err", err, exp_err);
    chk_val("busy_done", busy, 0);
    if (exp_err[0]) chk_val("timeout_gap", cyc - last_acc, TIMEOUT);
    start = 1'b0;
    tick();
    chk_val("done_clr", done, 0);
    chk = 0;
    tick();
  endtask

  initial begin
    reset_L = 1'b0; start = 1'b0; burst_len = '0; seed = '0; cfg_thr = '0;
    fifo_pause_main = 1'b0; fifo_empty = '1; data_out = '0;
    prev_pop = '0; prev_empty = '1; prev_push = 0; prev_drop = 0; prev_dest = 0;
    m_sent = 0; m_len = 0; m_seed = 0; drop_idx = -1; ps = 0; pl = 0; rnd_pause = 0;
    acc_total = 0; last_acc = 0;
    for (int i = 0; i < NUM_DEST; i++) pend[i] = 0;
    repeat (3) tick();
    chk_val("rst_push", push_main, 0);
    chk_val("rst_pop", pop, 0);
    chk_val("rst_thr", {afMF_i, aeMF_i, afVC_i, aeVC_i, afDF_i, aeDF_i}, 16'b11_01_1110_0010_11_01);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_cnt", sent_cnt, 0);
    reset_L = 1'b1;
    tick();

    run(44, 8, {2'd2, 2'd1, 4'd12, 4'd3, 2'd2, 2'd1, 4'h0}, -1, 0, 0, 0, 2'b00);
    run($urandom_range(0, 63), 10, 20'hA5B30, -1, 7, 5, 0, 2'b00);
    run(62, 4, 20'h3E2D0, -1, 0, 0, 0, 2'b00);
    run($urandom_range(0, 63), 3, 20'h5C710, 1, 0, 0, 0, 2'b01);
    run($urandom_range(0, 63), 0, 20'h12340, -1, 0, 0, 0, 2'b00);
    for (int k = 0; k < 5; k++)
      run($urandom_range(0, 63), $urandom_range(1, 20), 20'($urandom), -1, 0, 0, 1, 2'b00);

    // Reset asserted in the middle of a burst.
    seed = 6'd5; burst_len = 8'd20; cfg_thr = 20'hFFFF0; start = 1'b1;
    repeat (8) tick();
    reset_L = 1'b0;
    tick();
    chk_val("midrst_push", push_main, 0);
    chk_val("midrst_pop", pop, 0);
    chk_val("midrst_afVC", afVC_i, 14);
    chk_val("midrst_aeVC", aeVC_i, 2);
    chk_val("midrst_busy", busy, 0);
    chk_val("midrst_done", done, 0);
    chk_val("midrst_sent", sent_cnt, 0);
    repeat (2) tick();
    start = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) pend[i] = 0;
    fifo_empty = '1;
    reset_L = 1'b1;
    tick();
    prev_pop = '0; prev_push = 0; prev_empty = '1;
    run(10, 5, 20'h3E2D0, -1, 0, 0, 0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
